// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg
// Shared constants and types for the integer writeback path.
//   XLEN       : width of a writeback value
//   REG_ADDR_W : width of an integer register index
//   NUM_REGS   : number of architectural integer registers
//   wb_req_t   : one writeback request {destination register, value}
// ----------------------------------------------------------------------------
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/rv_wb_sched_if.sv
// ----------------------------------------------------------------------------
// rv_wb_sched_if
// Writeback source bundle for the scheduler: source A (execute/ALU) and
// source B (load unit).
//   i_a_valid / o_a_ready / i_a_rd / i_a_data : source A request channel
//   i_b_valid / o_b_ready / i_b_rd / i_b_data : source B request channel
// Modports:
//   master : the writeback sources (drive valid/rd/data, observe ready)
//   slave  : the scheduler (observes valid/rd/data, drives ready)
//
// Handshake: a request transfers in the cycle where valid && ready are both
// high. A source raising valid keeps rd/data stable until that cycle; ready
// is a combinational grant and may depend on valid in the same cycle.
// ----------------------------------------------------------------------------
interface rv_wb_sched_if #(
    parameter int XLEN = rv_pkg::XLEN
);

    logic                          i_a_valid;
    logic                          o_a_ready;
    logic [rv_pkg::REG_ADDR_W-1:0] i_a_rd;
    logic [XLEN-1:0]               i_a_data;

    logic                          i_b_valid;
    logic                          o_b_ready;
    logic [rv_pkg::REG_ADDR_W-1:0] i_b_rd;
    logic [XLEN-1:0]               i_b_data;

    modport master (
        output i_a_valid, i_a_rd, i_a_data,
        output i_b_valid, i_b_rd, i_b_data,
        input  o_a_ready, o_b_ready
    );

    modport slave (
        input  i_a_valid, i_a_rd, i_a_data,
        input  i_b_valid, i_b_rd, i_b_data,
        output o_a_ready, o_b_ready
    );

endinterface

// File: rtl/rv_wb_rr_arb.sv
// ----------------------------------------------------------------------------
// rv_wb_rr_arb
// Two-requester round-robin arbiter with a combinational grant.
//   i_clk     : clock
//   i_reset_n : asynchronous active-low reset (priority returns to req[0])
//   i_req     : request vector, bit 0 = source A, bit 1 = source B
//   o_gnt     : one-hot (or zero) grant vector, same bit order
// A lone requester is always granted. When both request, the one that was
// not granted most recently wins. The priority flop only moves on a grant.
// ----------------------------------------------------------------------------
module rv_wb_rr_arb (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    // 1: source A wins a tie, 0: source B wins a tie
    logic prio_a_q;
    logic prio_a_d;

    always_comb begin
        o_gnt[0] = i_req[0] && (!i_req[1] || prio_a_q);
        o_gnt[1] = i_req[1] && (!i_req[0] || !prio_a_q);
        prio_a_d = prio_a_q;
        if (o_gnt[0]) begin
            prio_a_d = 1'b0;
        end else if (o_gnt[1]) begin
            prio_a_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            prio_a_q <= 1'b1;
        end else begin
            prio_a_q <= prio_a_d;
        end
    end

endmodule

// File: rtl/rv_wb_sched.sv
// ----------------------------------------------------------------------------
// rv_wb_sched
// Writeback scheduler for the single write port of the integer register
// file, plus a per-register pending-write scoreboard for RAW stalls.
//   i_clk, i_reset_n            : clock, asynchronous active-low reset
//   wb (rv_wb_sched_if.slave)   : source A / source B writeback requests
//   i_issue, i_issue_rd         : decode issues an instruction writing rd
//   o_issue_ready               : scoreboard has room for that rd
//   i_rs1, i_rs2                : decode operand queries
//   o_rs1_busy, o_rs2_busy      : operand still has a pending write
//   o_rf_write/o_rf_rd/o_rf_data: registered register-file write port
// Optional build macro RV_WB_SCHED_FWD_EN adds o_rs1_fwd / o_rs2_fwd: the
// operand is being written this cycle by its last outstanding writer, so
// decode may take o_rf_data instead of stalling.
// ----------------------------------------------------------------------------
module rv_wb_sched #(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int CNT_W = 2
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    rv_wb_sched_if.slave                  wb,
    input  logic                          i_issue,
    output logic                          o_issue_ready,
    input  logic [rv_pkg::REG_ADDR_W-1:0] i_issue_rd,
    input  logic [rv_pkg::REG_ADDR_W-1:0] i_rs1,
    input  logic [rv_pkg::REG_ADDR_W-1:0] i_rs2,
    output logic                          o_rs1_busy,
    output logic                          o_rs2_busy,
    output logic                          o_rf_write,
    output logic [rv_pkg::REG_ADDR_W-1:0] o_rf_rd,
    output logic [XLEN-1:0]               o_rf_data
`ifdef RV_WB_SCHED_FWD_EN
    ,
    output logic                          o_rs1_fwd,
    output logic                          o_rs2_fwd
`endif
);

    import rv_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]          req;
    logic [1:0]          gnt;
    wb_req_t             sel_req;
    wb_req_t             wb_q;
    logic                rf_write_q;

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] inc_v;
    logic [NUM_REGS-1:0] dec_v;

    logic                rs1_pend;
    logic                rs2_pend;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign req = {wb.i_b_valid, wb.i_a_valid};

    rv_wb_rr_arb u_arb (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_req     (req),
        .o_gnt     (gnt)
    );

    assign wb.o_a_ready = gnt[0];
    assign wb.o_b_ready = gnt[1];

    always_comb begin
        sel_req.rd   = wb.i_a_rd;
        sel_req.data = wb.i_a_data;
        if (gnt[1]) begin
            sel_req.rd   = wb.i_b_rd;
            sel_req.data = wb.i_b_data;
        end
    end

    // ------------------------------------------------------------------
    // Registered write port. A granted rd=0 result is consumed but never
    // raises the write enable, so x0 is never written and never commits.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rf_write_q <= 1'b0;
            wb_q       <= '0;
        end else begin
            rf_write_q <= (|gnt) && (sel_req.rd != '0);
            if (|gnt) begin
                wb_q <= sel_req;
            end
        end
    end

    assign o_rf_write = rf_write_q;
    assign o_rf_rd    = wb_q.rd;
    assign o_rf_data  = wb_q.data;

    // ------------------------------------------------------------------
    // Scoreboard. Entry 0 exists only to keep indexing simple; it is never
    // incremented or decremented and stays at zero.
    // ------------------------------------------------------------------
    assign o_issue_ready = (i_issue_rd == '0) || (cnt_q[i_issue_rd] != CNT_MAX);

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        if (i_issue && o_issue_ready && (i_issue_rd != '0)) begin
            inc_v[i_issue_rd] = 1'b1;
        end
        // A commit against an empty counter is a protocol error; clamp at 0.
        if (rf_write_q && (cnt_q[wb_q.rd] != '0)) begin
            dec_v[wb_q.rd] = 1'b1;
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc_v[r] && !dec_v[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec_v[r] && !inc_v[r]) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand busy: from the counters only, this cycle's commit does not
    // clear busy unless forwarding is built in.
    // ------------------------------------------------------------------
    assign rs1_pend = (i_rs1 != '0) && (cnt_q[i_rs1] != '0);
    assign rs2_pend = (i_rs2 != '0) && (cnt_q[i_rs2] != '0);

`ifdef RV_WB_SCHED_FWD_EN
    // Forward only when the commit in flight is the last outstanding
    // writer; an older value would otherwise be handed to a younger reader.
    assign o_rs1_fwd  = rf_write_q && (wb_q.rd == i_rs1) && (i_rs1 != '0)
                        && (cnt_q[i_rs1] == CNT_W'(1));
    assign o_rs2_fwd  = rf_write_q && (wb_q.rd == i_rs2) && (i_rs2 != '0)
                        && (cnt_q[i_rs2] == CNT_W'(1));
    assign o_rs1_busy = rs1_pend && !o_rs1_fwd;
    assign o_rs2_busy = rs2_pend && !o_rs2_fwd;
`else
    assign o_rs1_busy = rs1_pend;
    assign o_rs2_busy = rs2_pend;
`endif

`ifndef SYNTHESIS
    commit_underflow_chk: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        !(rf_write_q && (cnt_q[wb_q.rd] == '0)));
`endif

endmodule
